posit_encoder_pipe: RTL and testbench

POSIT_ENCODER_PIPE -- requirements
Module: posit_encoder_pipe

---
 rtl/posit_defines.sv | 36 +++
 rtl/posit_lzc.sv | 18 +
 rtl/posit_encoder_pipe.sv | 155 +++++++++++++++
 tb/tb_posit_encoder_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_defines.sv
// Shared posit format constants, the decoded-operand type and the encoder stage-register types.
package posit_defines;

  localparam int NBITS = 32;
  localparam int ES    = 2;
  localparam int FBITS = NBITS - 2;
  localparam int ABITS = FBITS + 1;
  localparam int SW    = 10;

  typedef struct packed {
    logic                    sign;
    logic signed [8:0]       scale;
    logic [ES-1:0]           exponent;
    logic [ABITS-1:0]        fraction;
    logic                    inf;
    logic                    zero;
  } value_sum;

  typedef struct packed {
    logic                    sign;
    logic                    nar;
    logic                    zero;
    logic signed [SW-1:0]    scale_n;
    logic [ABITS-1:0]        frac;
  } enc_s1_t;

  typedef struct packed {
    logic                    sign;
    logic                    nar;
    logic                    zero;
    logic                    sat;
    logic                    inexact;
    logic [NBITS-2:0]        mag;
  } enc_s2_t;

endpackage

// File: rtl/posit_lzc.sv
// Leading-zero counter; returns WIDTH when the input is all zeros.
module posit_lzc #(
  parameter int WIDTH = 31,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    count_o = CW'(WIDTH);
    // Ascending scan: the highest set bit is the last to write the count.
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/posit_encoder_pipe.sv
// 3-stage posit encoder (normalise, regime/round, sign); valid/ready with a combinational ready chain.
// Optional status outputs (out_inexact, out_sat, sat_count) under POSIT_ENC_STATUS_EN.
module posit_encoder_pipe
  import posit_defines::*;
#(
  parameter int NBITS = posit_defines::NBITS,
  parameter int ES    = posit_defines::ES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  value_sum         in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_posit
`ifdef POSIT_ENC_STATUS_EN
  , output logic           out_inexact
  , output logic           out_sat
  , output logic [15:0]    sat_count
`endif
);

  localparam int LZW  = $clog2(ABITS + 1);
  localparam int BODY = 2 + ES + ABITS - 1;
  localparam int XW   = BODY + NBITS - 2;
  localparam logic signed [SW-1:0] MAXS = SW'((NBITS - 2) << ES);

  logic             s1_vld_q, s2_vld_q, out_vld_q;
  enc_s1_t          s1_q, s1_d;
  enc_s2_t          s2_q, s2_d;
  logic [NBITS-1:0] out_posit_q, out_posit_d;
  logic             s2_rdy, s3_rdy;
  logic [LZW-1:0]   lz;

  assign s3_rdy    = !out_vld_q || out_ready;
  assign s2_rdy    = !s2_vld_q || s3_rdy;
  assign in_ready  = !s1_vld_q || s2_rdy;
  assign out_valid = out_vld_q;
  assign out_posit = out_posit_q;

  posit_lzc #(.WIDTH(ABITS), .CW(LZW)) u_lzc (
    .data_i  (in_value.fraction),
    .count_o (lz)
  );

  always_comb begin
    s1_d         = '0;
    s1_d.sign    = in_value.sign;
    s1_d.nar     = in_value.inf;
    s1_d.zero    = !in_value.inf && (in_value.zero || (in_value.fraction == '0));
    s1_d.frac    = in_value.fraction << lz;
    s1_d.scale_n = {in_value.scale[8], in_value.scale} - {{(SW-LZW){1'b0}}, lz};
  end

  logic signed [SW-1:0] sn, k;
  logic [SW-1:0]        sh;
  logic                 first, guard, sticky, round_up;
  logic signed [XW-1:0] x;
  logic [NBITS-2:0]     mag_t, mag_r;

  always_comb begin
    sn    = s1_q.scale_n;
    k     = sn >>> ES;
    first = !k[SW-1];
    // Regime run length minus one: k for k>=0, -k-1 (= ~k) for k<0.
    sh    = first ? k : ~k;
    x     = $signed({first, !first, sn[ES-1:0], s1_q.frac[ABITS-2:0],
                     {(NBITS-2){1'b0}}}) >>> sh;
    mag_t    = x[XW-1 -: NBITS-1];
    guard    = x[XW-NBITS];
    sticky   = |x[XW-NBITS-1:0];
    round_up = guard && (sticky || mag_t[0]);
    mag_r    = (round_up && !(&mag_t)) ? mag_t + 1'b1 : mag_t;

    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.nar  = s1_q.nar;
    s2_d.zero = s1_q.zero;
    if (!s1_q.nar && !s1_q.zero) begin
      if (sn > MAXS) begin
        s2_d.mag = '1;
        s2_d.sat = 1'b1;
      end else if (sn < -MAXS) begin
        s2_d.mag = {{(NBITS-2){1'b0}}, 1'b1};
        s2_d.sat = 1'b1;
      end else begin
        s2_d.mag = mag_r;
      end
      s2_d.inexact = s2_d.sat || guard || sticky;
    end
  end

  always_comb begin
    out_posit_d = {1'b0, s2_q.mag};
    if (s2_q.nar)       out_posit_d = {1'b1, {(NBITS-1){1'b0}}};
    else if (s2_q.zero) out_posit_d = '0;
    else if (s2_q.sign) out_posit_d = -{1'b0, s2_q.mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      out_vld_q   <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_posit_q <= '0;
    end else begin
      if (in_ready) begin
        s1_vld_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_rdy) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) s2_q <= s2_d;
      end
      if (s3_rdy) begin
        out_vld_q <= s2_vld_q;
        if (s2_vld_q) out_posit_q <= out_posit_d;
      end
    end
  end

`ifdef POSIT_ENC_STATUS_EN
  logic        out_inexact_q, out_sat_q;
  logic [15:0] sat_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inexact_q <= 1'b0;
      out_sat_q     <= 1'b0;
      sat_count_q   <= '0;
    end else begin
      if (s3_rdy && s2_vld_q) begin
        out_inexact_q <= s2_q.inexact;
        out_sat_q     <= s2_q.sat;
      end
      if (out_vld_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF))
        sat_count_q <= sat_count_q + 16'd1;
    end
  end

  assign out_inexact = out_inexact_q;
  assign out_sat     = out_sat_q;
  assign sat_count   = sat_count_q;

  logic unused_bits;
  assign unused_bits = ^{in_value.exponent, s1_q.frac[ABITS-1]};
`else
  logic unused_bits;
  assign unused_bits = ^{in_value.exponent, s1_q.frac[ABITS-1], s2_q.sat, s2_q.inexact};
`endif

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Randomized and directed bench for posit_encoder_pipe with a bit-string reference model and scoreboard.
module tb_posit_encoder_pipe;
  import posit_defines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  value_sum    in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;
`ifdef POSIT_ENC_STATUS_EN
  logic        out_inexact;
  logic        out_sat;
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  posit_encoder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
`ifdef POSIT_ENC_STATUS_EN
    , .out_inexact (out_inexact)
    , .out_sat     (out_sat)
    , .sat_count   (sat_count)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  bit          rand_rdy = 0;
  logic [32:0] exp_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: write the posit as a string of bits (regime run, terminator,
  // exponent, fraction), cut at 31 bits, round to nearest-even, then negate.
  function automatic logic [32:0] model(value_sum v);
    logic [ABITS-1:0] f;
    logic [30:0]      mag;
    logic [31:0]      res;
    logic [1:0]       ev;
    bit               q[$];
    bit               g, st, sat;
    int               l, sn, k;
    if (v.inf) return {1'b0, 32'h8000_0000};
    if (v.zero || v.fraction == '0) return '0;
    f = v.fraction;
    l = 0;
    while (!f[ABITS-1]) begin f = f << 1; l++; end
    sn  = int'(v.scale) - l;
    sat = 0;
    if (sn > 120) begin mag = '1; sat = 1; end
    else if (sn < -120) begin mag = 31'd1; sat = 1; end
    else begin
      k  = (sn >= 0) ? sn / 4 : -((3 - sn) / 4);
      ev = 2'(sn - 4 * k);
      if (k >= 0) begin repeat (k + 1) q.push_back(1); q.push_back(0); end
      else begin repeat (-k) q.push_back(0); q.push_back(1); end
      q.push_back(ev[1]);
      q.push_back(ev[0]);
      for (int i = ABITS - 2; i >= 0; i--) q.push_back(f[i]);
      mag = '0;
      for (int i = 0; i < 31; i++) mag = {mag[29:0], q[i]};
      g  = q[31];
      st = 0;
      for (int i = 32; i < q.size(); i++) st |= q[i];
      if (g && (st || mag[0]) && mag != '1) mag = mag + 31'd1;
    end
    res = {1'b0, mag};
    if (v.sign) res = -res;
    return {sat, res};
  endfunction

  function automatic value_sum mk(bit s, int sc, logic [ABITS-1:0] f, bit inf = 0, bit z = 0);
    value_sum v;
    v          = '0;
    v.sign     = s;
    v.scale    = 9'(sc);
    v.fraction = f;
    v.inf      = inf;
    v.zero     = z;
    return v;
  endfunction

  function automatic value_sum rand_op();
    value_sum v;
    v          = '0;
    v.sign     = 1'($urandom);
    v.scale    = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 260) - 130);
    v.exponent = 2'($urandom);
    v.fraction = 31'($urandom);
    case ($urandom_range(0, 3))
      0: v.fraction = v.fraction >> $urandom_range(0, 31);
      1: v.fraction[30] = 1'b1;
      default: ;
    endcase
    v.inf  = ($urandom_range(0, 15) == 0);
    v.zero = ($urandom_range(0, 15) == 0);
    return v;
  endfunction

  // Scoreboard/monitor: sampled at the falling edge, between active edges.
  initial begin : monitor
    logic        hold;
    logic [31:0] held;
    logic [32:0] e;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_posit", out_posit, held);
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
          else begin
            e = exp_q.pop_front();
            check("posit", out_posit, e[31:0]);
`ifdef POSIT_ENC_STATUS_EN
            check("sat_flag", out_sat, e[32]);
`endif
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_value));
        hold = out_valid && !out_ready;
        held = out_posit;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(value_sum v);
    bit acc;
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_value = v;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  value_sum    dir_op[12];
  logic [31:0] dir_exp[12];
  value_sum    bp[6];

  initial begin : main
    int idx, base, cnt;
    bit r;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_posit", out_posit, 0);
`ifdef POSIT_ENC_STATUS_EN
    check("rst_sat_count", sat_count, 0);
`endif
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    dir_op[0]  = mk(0, 0, 31'h4000_0000);       dir_exp[0]  = 32'h4000_0000;
    dir_op[1]  = mk(1, 0, 31'h4000_0000);       dir_exp[1]  = 32'hC000_0000;
    dir_op[2]  = mk(0, 4, 31'h4000_0000);       dir_exp[2]  = 32'h6000_0000;
    dir_op[3]  = mk(0, 1, 31'h2000_0000);       dir_exp[3]  = 32'h4000_0000;
    dir_op[4]  = mk(0, 200, 31'h4000_0000);     dir_exp[4]  = 32'h7FFF_FFFF;
    dir_op[5]  = mk(0, -200, 31'h4000_0000);    dir_exp[5]  = 32'h0000_0001;
    dir_op[6]  = mk(0, 0, 31'h4000_0000, 0, 1); dir_exp[6]  = 32'h0000_0000;
    dir_op[7]  = mk(0, 0, 31'h4000_0000, 1, 1); dir_exp[7]  = 32'h8000_0000;
    dir_op[8]  = mk(0, 0, 31'h4000_000C);       dir_exp[8]  = 32'h4000_0002;
    dir_op[9]  = mk(0, 0, 31'h4000_0004);       dir_exp[9]  = 32'h4000_0000;
    dir_op[10] = mk(0, 5, 31'h0000_0000);       dir_exp[10] = 32'h0000_0000;
    dir_op[11] = mk(1, 4, 31'h4000_0000);       dir_exp[11] = 32'hA000_0000;

    for (int i = 0; i < 12; i++)
      check($sformatf("model_dir%0d", i), model(dir_op[i]) & 33'h0_FFFF_FFFF, dir_exp[i]);
    check("model_sat_hi", model(dir_op[4]) >> 32, 1);
    check("model_sat_lo", model(dir_op[5]) >> 32, 1);

    send(dir_op[0]);
    @(negedge clk);
    check("lat_c1", out_valid, 0);
    @(negedge clk);
    check("lat_c2", out_valid, 0);
    @(negedge clk);
    check("lat_c3", out_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 12; i++) send(dir_op[i]);
    drain();

    // Back-pressure: out_ready low for 5 cycles while 6 operands are offered.
    for (int i = 0; i < 6; i++) bp[i] = rand_op();
    base      = n_out;
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_value  = bp[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      r = in_ready;
      if (c >= 3) check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
      @(posedge clk);
      #1;
      if (r) begin
        idx++;
        in_value = bp[idx];
      end
    end
    check("bp_accepted", idx, 3);
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) send(bp[i]);
    drain();
    check("bp_count", n_out - base, 6);

    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send(rand_op());
    end
    rand_rdy = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with two operands in flight.
    out_ready = 1'b0;
    send(mk(0, 200, 31'h4000_0000));
    send(mk(1, 3, 31'h5555_5555));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cnt       = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(out_valid);
    end
    check("rst_no_emit", cnt, 0);
`ifdef POSIT_ENC_STATUS_EN
    check("rst_sat_count_mid", sat_count, 0);
`endif
    @(posedge clk);
    #1;
    base = n_out;
    send(dir_op[2]);
    drain();
    check("post_rst_count", n_out - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
